// File: rtl/sram_data_responder.sv
// Data-bus target that turns one initiator access into a timed strobe sequence on an asynchronous 16-bit SRAM.
// Optional macro SRAM_POSTED_WRITE_EN: acknowledge writes in WR_SETUP while the SRAM cycle completes from captured registers.
module sram_data_responder #(
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [19:1]           m_addr,
    output logic [15:0]           m_data_out,
    input  logic [15:0]           m_data_in,
    input  logic                  m_access,
    output logic                  m_ack,
    input  logic                  m_wr_en,
    input  logic [1:0]            m_bytesel,
    input  logic                  io,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [15:0]           sram_dq_in,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n,
    output logic [2:0]            dbg_state
);

    // Handshake: the initiator raises m_access and holds it (with address, data, bytesel, wr_en)
    // until m_ack pulses for one cycle; a request is only taken in IDLE, so a held request simply stalls.
    typedef enum logic [2:0] {
        IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, ACK, TURN
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wdata_q;
    logic [1:0]            bytesel_q;
    logic [15:0]           rdata_q;
    logic                  capture;
    logic                  read_done;
    logic                  lanes_on;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^m_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        capture    = 1'b0;
        read_done  = 1'b0;
        lanes_on   = 1'b0;
        m_ack      = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_access && !io) begin
                    capture = 1'b1;
                    wait_d  = 4'd0;
                    if (m_bytesel == 2'b00) state_d = ACK;
                    else if (m_wr_en)       state_d = WR_SETUP;
                    else                    state_d = READ;
                end
            end
            READ: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                lanes_on  = 1'b1;
                if (wait_q == WAIT_LAST) begin
                    read_done = 1'b1;
                    wait_d    = 4'd0;
                    state_d   = ACK;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                lanes_on   = 1'b1;
`ifdef SRAM_POSTED_WRITE_EN
                m_ack      = 1'b1;
`endif
                wait_d     = 4'd0;
                state_d    = WR_PULSE;
            end
            WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                sram_we_n  = 1'b0;
                lanes_on   = 1'b1;
                if (wait_q == WAIT_LAST) begin
                    wait_d  = 4'd0;
                    state_d = WR_HOLD;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                lanes_on   = 1'b1;
`ifndef SRAM_POSTED_WRITE_EN
                m_ack      = 1'b1;
`endif
                state_d    = TURN;
            end
            ACK: begin
                m_ack   = 1'b1;
                state_d = TURN;
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; the SRAM side never looks at live bus inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            bytesel_q <= 2'b00;
            rdata_q   <= 16'h0000;
        end else begin
            if (capture) begin
                addr_q    <= m_addr[ADDR_WIDTH:1];
                wdata_q   <= m_data_in;
                bytesel_q <= m_bytesel;
            end
            if (read_done) begin
                rdata_q <= {bytesel_q[1] ? sram_dq_in[15:8] : 8'h00,
                            bytesel_q[0] ? sram_dq_in[7:0]  : 8'h00};
            end else if (capture && !m_wr_en && (m_bytesel == 2'b00)) begin
                rdata_q <= 16'h0000;
            end
        end
    end

    assign m_data_out  = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign sram_lb_n   = lanes_on ? ~bytesel_q[0] : 1'b1;
    assign sram_ub_n   = lanes_on ? ~bytesel_q[1] : 1'b1;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_data_responder.sv
// Directed bench for sram_data_responder: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_sram_data_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [19:1] m_addr;
  logic [15:0] m_data_in;
  logic [15:0] sram_dq_in;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;
  logic        io;
  logic        acc1, acc0;
  logic        sel;

  logic [15:0] d1_data, d0_data, d1_dq, d0_dq;
  logic [17:0] d1_addr, d0_addr;
  logic        d1_ack, d0_ack, d1_oe, d0_oe;
  logic        d1_ce_n, d0_ce_n, d1_oe_n, d0_oe_n, d1_we_n, d0_we_n;
  logic        d1_lb_n, d0_lb_n, d1_ub_n, d0_ub_n;
  logic [2:0]  d1_dbg, d0_dbg;

  sram_data_responder #(.ADDR_WIDTH(18), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .m_addr(m_addr), .m_data_out(d1_data),
    .m_data_in(m_data_in), .m_access(acc1), .m_ack(d1_ack), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .io(io), .sram_addr(d1_addr), .sram_dq_in(sram_dq_in),
    .sram_dq_out(d1_dq), .sram_dq_oe(d1_oe), .sram_ce_n(d1_ce_n), .sram_oe_n(d1_oe_n),
    .sram_we_n(d1_we_n), .sram_lb_n(d1_lb_n), .sram_ub_n(d1_ub_n), .dbg_state(d1_dbg)
  );

  sram_data_responder #(.ADDR_WIDTH(18), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .m_addr(m_addr), .m_data_out(d0_data),
    .m_data_in(m_data_in), .m_access(acc0), .m_ack(d0_ack), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .io(io), .sram_addr(d0_addr), .sram_dq_in(sram_dq_in),
    .sram_dq_out(d0_dq), .sram_dq_oe(d0_oe), .sram_ce_n(d0_ce_n), .sram_oe_n(d0_oe_n),
    .sram_we_n(d0_we_n), .sram_lb_n(d0_lb_n), .sram_ub_n(d0_ub_n), .dbg_state(d0_dbg)
  );

  // Outputs of whichever instance is under test.
  logic [15:0] o_data, o_dq;
  logic [17:0] o_addr;
  logic        o_ack, o_dq_oe, o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n;
  logic [2:0]  o_dbg;
  assign o_data  = sel ? d1_data : d0_data;
  assign o_dq    = sel ? d1_dq   : d0_dq;
  assign o_addr  = sel ? d1_addr : d0_addr;
  assign o_ack   = sel ? d1_ack  : d0_ack;
  assign o_dq_oe = sel ? d1_oe   : d0_oe;
  assign o_ce_n  = sel ? d1_ce_n : d0_ce_n;
  assign o_oe_n  = sel ? d1_oe_n : d0_oe_n;
  assign o_we_n  = sel ? d1_we_n : d0_we_n;
  assign o_lb_n  = sel ? d1_lb_n : d0_lb_n;
  assign o_ub_n  = sel ? d1_ub_n : d0_ub_n;
  assign o_dbg   = sel ? d1_dbg  : d0_dbg;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-access observations, cycle 0 = IDLE cycle that samples the request.
  int          r_ack_cycle, r_ack_cnt, r_ce_low, r_oe_low, r_oe_first, r_we_low;
  int          r_dqoe_cnt, r_dqoe_first, r_dqoe_last, r_conflict;
  logic        r_lb_n, r_ub_n, r_seen;
  logic [17:0] r_addr;
  logic [15:0] r_ack_data, r_wdata;

  task automatic clear_obs();
    r_ack_cycle = -1; r_ack_cnt = 0; r_ce_low = 0; r_oe_low = 0; r_oe_first = -1;
    r_we_low = 0; r_dqoe_cnt = 0; r_dqoe_first = -1; r_dqoe_last = -1; r_conflict = 0;
    r_lb_n = 1'b1; r_ub_n = 1'b1; r_seen = 1'b0; r_addr = '0; r_ack_data = '0; r_wdata = '0;
  endtask

  task automatic observe(input int n);
    if (!o_ce_n) r_ce_low++;
    if (!o_oe_n) begin
      r_oe_low++;
      if (r_oe_first < 0) r_oe_first = n;
    end
    if (!o_we_n) begin
      r_we_low++;
      r_wdata = o_dq;
    end
    if (o_dq_oe) begin
      r_dqoe_cnt++;
      if (r_dqoe_first < 0) r_dqoe_first = n;
      r_dqoe_last = n;
    end
    if (!o_oe_n && (!o_we_n || o_dq_oe)) r_conflict++;
    if (!o_ce_n && !r_seen) begin
      r_seen = 1'b1; r_lb_n = o_lb_n; r_ub_n = o_ub_n; r_addr = o_addr;
    end
    if (o_ack) begin
      r_ack_cnt++;
      if (r_ack_cycle < 0) r_ack_cycle = n;
      r_ack_data = o_data;
    end
  endtask

  task automatic run(input logic s, input logic [19:1] a, input logic [15:0] wd, input logic wr,
                     input logic [1:0] bs, input logic [15:0] rd);
    sel = s; m_addr = a; m_data_in = wd; m_wr_en = wr; m_bytesel = bs; sram_dq_in = rd;
    if (s) acc1 = 1'b1; else acc0 = 1'b1;
    clear_obs();
    #1;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) step();
      observe(n);
      if (o_ack) begin
        acc1 = 1'b0; acc0 = 1'b0;
        // Initiator changes its bus once acked; the responder must not care.
        m_addr = 19'h7FFFF; m_data_in = 16'hFFFF;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; acc1 = 1'b0; acc0 = 1'b0; sel = 1'b1; io = 1'b0;
    m_addr = '0; m_data_in = '0; m_wr_en = 1'b0; m_bytesel = 2'b00; sram_dq_in = '0;
    step();
    check_val("rst_ack", o_ack, 0);
    check_val("rst_data", o_data, 0);
    check_val("rst_addr", o_addr, 0);
    check_val("rst_dq", {o_dq_oe, o_dq}, 0);
    check_val("rst_strobes", {o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n}, 5'b11111);
    check_val("rst_state", o_dbg, 0);
    step();
    reset_n = 1'b1;
    step();

    // Full-word read, one wait state.
    run(1'b1, 19'h00123, 16'h0000, 1'b0, 2'b11, 16'hBEEF);
    check_val("rd_addr", r_addr, 18'h00123);
    check_val("rd_oe_low", r_oe_low, 2);
    check_val("rd_oe_first", r_oe_first, 1);
    check_val("rd_ack_cycle", r_ack_cycle, 3);
    check_val("rd_ack_cnt", r_ack_cnt, 1);
    check_val("rd_data", r_ack_data, 16'hBEEF);
    check_val("rd_no_write", {r_we_low[7:0], r_dqoe_cnt[7:0]}, 0);
    check_val("rd_data_hold", o_data, 16'hBEEF);

    // High byte only.
    run(1'b1, 19'h00200, 16'h0000, 1'b0, 2'b10, 16'h1234);
    check_val("rdh_lanes", {r_lb_n, r_ub_n}, 2'b10);
    check_val("rdh_data", r_ack_data, 16'h1200);

    // Reset while in READ.
    sel = 1'b1; m_addr = 19'h00456; m_bytesel = 2'b11; m_wr_en = 1'b0; sram_dq_in = 16'hCAFE;
    acc1 = 1'b1;
    step();
    check_val("mid_pre_ce", o_ce_n, 0);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_strobes", {o_ce_n, o_oe_n}, 2'b11);
    check_val("mid_rst_ack", o_ack, 0);
    check_val("mid_rst_data", o_data, 0);
    acc1 = 1'b0;
    step();
    check_val("mid_rst_ack2", o_ack, 0);
    reset_n = 1'b1;
    step();
    // Upper address bit beyond ADDR_WIDTH is dropped.
    run(1'b1, 19'h7ABCD, 16'h0000, 1'b0, 2'b01, 16'h0F0F);
    check_val("post_rst_addr", r_addr, 18'h3ABCD);
    check_val("post_rst_ack_cycle", r_ack_cycle, 3);
    check_val("post_rst_data", r_ack_data, 16'h000F);

    // Low-byte write, zero wait states.
    run(1'b0, 19'h00042, 16'hA55A, 1'b1, 2'b01, 16'h0000);
    check_val("wr_we_low", r_we_low, 1);
    check_val("wr_lanes", {r_lb_n, r_ub_n}, 2'b01);
    check_val("wr_dqoe_span", {r_dqoe_first[7:0], r_dqoe_last[7:0], r_dqoe_cnt[7:0]}, 24'h010303);
    check_val("wr_oe_low", r_oe_low, 0);
    check_val("wr_conflict", r_conflict, 0);
    check_val("wr_dq", r_wdata, 16'hA55A);
    check_val("wr_addr", r_addr, 18'h00042);
`ifdef SRAM_POSTED_WRITE_EN
    check_val("wr_ack_cycle", r_ack_cycle, 1);
`else
    check_val("wr_ack_cycle", r_ack_cycle, 3);
`endif
    check_val("wr_ack_cnt", r_ack_cnt, 1);

    // I/O-space request must be ignored.
    sel = 1'b1; io = 1'b1; m_bytesel = 2'b11; m_wr_en = 1'b1; acc1 = 1'b1;
    clear_obs();
    for (int n = 0; n < 20; n++) begin
      step();
      observe(n);
    end
    check_val("io_strobes", r_ce_low + r_we_low + r_dqoe_cnt, 0);
    check_val("io_ack", r_ack_cnt, 0);
    acc1 = 1'b0; io = 1'b0;
    step();
    check_val("io_state", o_dbg, 0);

    // No byte lanes: immediate ack, zero data, no chip enable.
    run(1'b1, 19'h00300, 16'h0000, 1'b0, 2'b00, 16'h5555);
    check_val("bs0_ack_cycle", r_ack_cycle, 1);
    check_val("bs0_data", r_ack_data, 0);
    check_val("bs0_ce", r_ce_low, 0);

`ifdef SRAM_POSTED_WRITE_EN
    begin
      int ack1, ack2, acks;
      logic [17:0] rd_addr_seen;
      sel = 1'b0; m_addr = 19'h00010; m_data_in = 16'h1357; m_wr_en = 1'b1;
      m_bytesel = 2'b11; sram_dq_in = 16'h2468; acc0 = 1'b1;
      clear_obs();
      ack1 = -1; ack2 = -1; acks = 0; rd_addr_seen = '0;
      #1;
      for (int n = 0; n < 10; n++) begin
        if (n > 0) step();
        observe(n);
        if (!o_oe_n && n == r_oe_first) rd_addr_seen = o_addr;
        if (o_ack) begin
          acks++;
          if (ack1 < 0) begin
            ack1 = n;
            m_wr_en = 1'b0; m_addr = 19'h00020;
          end else begin
            ack2 = n;
            acc0 = 1'b0;
          end
        end
      end
      check_val("pw_wr_ack", ack1, 1);
      check_val("pw_rd_oe_first", r_oe_first, 6);
      check_val("pw_rd_ack", ack2, 7);
      check_val("pw_acks", acks, 2);
      check_val("pw_we_low", r_we_low, 1);
      check_val("pw_wdata", r_wdata, 16'h1357);
      check_val("pw_rd_addr", rd_addr_seen, 18'h00020);
      check_val("pw_rd_data", o_data, 16'h2468);
      check_val("pw_conflict", r_conflict, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_data_responder.md
Name: sram_data_responder

Overview:
- Bus responder (target) for the core's data memory bus (addr [19:1], 16-bit data, bytesel, wr_en, access/ack) and the initiator's counterpart.
- Converts each requested access into a timed strobe sequence on an external asynchronous 16-bit SRAM with programmable wait states.
- Returns a one-cycle ack, plus registered read data for reads.
- Sits between the core's data port and board SRAM; I/O-space accesses (io=1) are left to a separate I/O decoder.

Parameters:
- ADDR_WIDTH, 18: SRAM word-address width (1..19); uses m_addr[ADDR_WIDTH:1].
- WAIT_STATES, 1: extra cycles of strobe assertion (0..15).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous reset, active-low.
- m_addr  input  19  word address [19:1].
- m_data_out  output  16  read data to initiator.
- m_data_in  input  16  write data from initiator.
- m_access  input  1  request, held high until ack.
- m_ack  output  1  one-cycle completion pulse.
- m_wr_en  input  1  1=write, 0=read.
- m_bytesel  input  2  [0]=low byte, [1]=high byte.
- io  input  1  I/O-space access; block ignores request when 1.
- sram_addr  output  ADDR_WIDTH  SRAM address.
- sram_dq_in  input  16  SRAM data bus input.
- sram_dq_out  output  16  SRAM data bus output.
- sram_dq_oe  output  1  drive enable for sram_dq_out.
- sram_ce_n  output  1  chip enable, active-low.
- sram_oe_n  output  1  output enable, active-low.
- sram_we_n  output  1  write enable, active-low.
- sram_lb_n  output  1  low-byte lane enable, active-low.
- sram_ub_n  output  1  high-byte lane enable, active-low.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; m_ack=0, m_data_out=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, all *_n=1. Takes effect mid-access immediately; no ack is issued for the aborted access.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, ACK, TURN. A wait counter runs 0..WAIT_STATES.
- IDLE: on m_access=1 & io=0, capture addr, data, bytesel, wr_en into registers. All SRAM outputs come from these registers only.
- bytesel==2'b00: go to ACK with no SRAM strobes; read data = 0.
- Read path: READ holds ce_n=0, oe_n=0, lanes per bytesel, for WAIT_STATES+1 cycles. On the last READ cycle, register sram_dq_in into m_data_out with unselected bytes forced to 0, then go to ACK.
- Write path: WR_SETUP (1 cycle): ce_n=0, dq_oe=1, we_n=1. WR_PULSE: we_n=0 for WAIT_STATES+1 cycles. WR_HOLD: we_n=1 with dq_oe and ce_n still asserted, and m_ack=1 in this cycle. Then go to TURN.
- ACK: m_ack=1 for exactly one cycle; ce_n/oe_n=1. Then go to TURN.
- TURN: 1 cycle; m_access is ignored here so the initiator can drop it. Then go to IDLE.
- Latency, counted from the IDLE cycle sampling the request as cycle 0:
  - Read: ack at cycle WAIT_STATES+2.
  - Write: ack at cycle WAIT_STATES+3.
  - Back-to-back: next request is sampled no earlier than 2 cycles after ack.
- m_data_out holds its value until the next read completes.
- Never assert oe_n=0 and we_n=0 together. sram_dq_oe=1 only in WR_* states.
- Inputs that change while busy (address, data, m_access) have no effect. io rising mid-access has no effect.

Optional Feature:
- Macro: SRAM_POSTED_WRITE_EN.
- Defined: writes ack at cycle 1 (one-cycle pulse in WR_SETUP) while the SRAM write completes from captured registers. WR_HOLD issues no ack and goes to TURN. A request arriving before IDLE is stalled without ack until the write sequence finishes. Reads are unchanged.
- Undefined: write ack occurs in WR_HOLD as above.

Test Plan:
- Reset mid-read (WAIT_STATES=1): deassert reset_n in READ -> same-cycle ce_n=oe_n=1, m_ack=0, next accepted request proceeds normally.
- Read, addr=19'h00123, bytesel=2'b11, SRAM returns 16'hBEEF, WAIT_STATES=1 -> sram_addr=18'h00123, oe_n low 2 cycles, m_ack at cycle 3, m_data_out=16'hBEEF.
- Read, bytesel=2'b10, SRAM returns 16'h1234 -> lb_n=1, ub_n=0, m_data_out=16'h1200.
- Write 16'hA55A, bytesel=2'b01, WAIT_STATES=0 -> we_n low exactly 1 cycle, lb_n=0, ub_n=1, dq_oe covers setup..hold, m_ack at cycle 3; oe_n stays high throughout.
- io=1 with m_access=1 for 20 cycles -> no strobes, m_ack stays 0. bytesel=0 read -> ack at cycle 1, data 0, no ce_n.
- SRAM_POSTED_WRITE_EN: write immediately followed by read -> write ack at cycle 1; read strobes start only after WR_HOLD+TURN; data correct.
